bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
Downstream consumer of the binary-to-BCD converter's 10-bit BCD word. It captures BCD values through a valid/ready handshake into a shadow register and promotes them to the displayed register only at frame boundaries, so the display never tears. It drives a 3-digit time-multiplexed 7-segment display with per-digit segment decode, leading-zero blanking and an invalid-digit indication.

Parameters:
SCAN_DIV, 1000, clock cycles each digit stays enabled; legal range >= 1
BLANK_LZ, 1, 1 = blank leading zeros; 0 = always show all three digits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  bcd_in holds a word to load
in_ready  output  1  block can accept a word this cycle
bcd_in  input  10  BCD word: [3:0] ones, [7:4] tens, [9:8] hundreds (0-3)
seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high
an  output  3  one-hot digit enable: an[0] ones, an[1] tens, an[2] hundreds
frame_done  output  1  one-cycle pulse when the last digit of a frame finishes
err  output  1  displayed word has a ones or tens nibble > 9

Behaviour:
- Reset: rst sampled low at a clk rising edge clears everything.
  - shadow = 0, pending = 0, active = 0
  - prescaler = 0, digit index = 0
  - seg = 0, an = 000, frame_done = 0, err = 0
  - in_ready = 1 (in_ready = ~pending, combinational from the register)
- Reset mid-operation drops any pending word. No partial state survives.
- Handshake:
  - A word is accepted when in_valid & in_ready at a rising edge: shadow <= bcd_in, pending <= 1.
  - in_ready stays 0 while pending = 1.
  - bcd_in is don't-care when in_valid = 0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On terminal count the prescaler wraps to 0 and the digit index advances 0 -> 1 -> 2 -> 0.
  - SCAN_DIV = 1 advances the digit index every cycle.
- Frame boundary (index 2 -> 0):
  - frame_done = 1 for exactly that one cycle, registered.
  - If pending was 1 before the edge: active <= shadow and pending <= 0.
- Simultaneous events:
  - At a boundary with pending = 1, in_ready is 0, so there is no accept; a new word can be accepted from the next cycle.
  - An accept on a boundary cycle with pending = 0 sets pending only. The word is promoted at the next boundary.
- Outputs:
  - an and seg are registered and reflect the digit index and the active register of the previous cycle (1-cycle latency).
  - After reset release, an = 001 from the second cycle onward.
- Segment decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values 10-15 display 79 ('E').
- Blanking (when BLANK_LZ = 1):
  - Hundreds is blanked when hundreds == 0.
  - Tens is blanked when hundreds == 0 and tens == 0.
  - Ones is never blanked.
  - A blanked digit drives seg = 00 while its an bit is still asserted.
- err:
  - Registered; recomputed whenever active loads.
  - err = (active ones > 9) | (active tens > 9).

Test Plan:
- Reset scan check, SCAN_DIV = 4, hold rst = 0 for 2 cycles, then release.
  - During reset: in_ready = 1, an = 000, seg = 00.
  - After release: an cycles 001 / 010 / 100, 4 cycles each.
  - Ones digit shows seg = 3F; tens and hundreds show seg = 00.
- Load and promote: send bcd_in = 10'h125 with one in_valid cycle.
  - in_ready = 0 until the next frame_done.
  - Following frame: ones = 6D, tens = 5B, hundreds = 06; in_ready returns to 1.
- Leading-zero blanking:
  - 10'h007 -> 07 / 00 / 00.
  - 10'h205 -> 6D / 3F / 5B.
  - Repeat 10'h007 with BLANK_LZ = 0 -> 07 / 3F / 3F.
- Invalid digit: 10'h0A3 -> after promotion err = 1, tens seg = 79, ones = 4F. A following load of 10'h042 clears err.
- Back-pressure: in_valid held high with 10'h011, then 10'h022 in the same frame.
  - The first word is accepted; the second is held with in_ready = 0 until the boundary.
  - The second is accepted the cycle after frame_done and displayed one frame later, in order.
- Reset mid-frame with pending = 1: one rst = 0 cycle.
  - pending is cleared, in_ready = 1, active = 0.
  - The old word never appears on seg.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Valid/ready load channel carrying a 10-bit BCD word into the display scanner.
interface bcd_display_scanner_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] bcd_in;

  // Producer side: offers a word and watches for ready.
  modport master (
    output in_valid,
    output bcd_in,
    input  in_ready
  );

  // Scanner side: accepts a word when it has room.
  modport slave (
    input  in_valid,
    input  bcd_in,
    output in_ready
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// 3-digit multiplexed 7-segment scanner for a BCD word (hundreds 0-3).
// Words land in a shadow register and are promoted to the displayed word
// only at a frame boundary, so a digit never shows half of an update.
module bcd_display_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  bcd_display_scanner_if.slave        bus,
  output logic [6:0]                  seg,
  output logic [2:0]                  an,
  output logic                        frame_done,
  output logic                        err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2
  } digit_t;

  logic [PW-1:0] prescale_reg;
  logic [PW-1:0] prescale_next;
  digit_t        digit_reg;
  digit_t        digit_next;
  logic          scan_tc;
  logic          frame_edge;

  logic [9:0]    shadow_reg;
  logic          pending_reg;
  logic [9:0]    active_reg;
  logic          accept;

  logic [6:0]    seg_reg;
  logic [6:0]    seg_next;
  logic [2:0]    an_reg;
  logic [2:0]    an_next;
  logic          frame_done_reg;
  logic          err_reg;
  logic [3:0]    nib;
  logic          blank;

  // Seven-segment pattern {g,f,e,d,c,b,a}; anything above 9 shows 'E'.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  // The shadow slot is free whenever no word is waiting for promotion.
  assign bus.in_ready = ~pending_reg;
  assign accept       = bus.in_valid & ~pending_reg;

  // Prescaler and digit-index state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_reg <= '0;
      digit_reg    <= DIG_ONES;
    end else begin
      prescale_reg <= prescale_next;
      digit_reg    <= digit_next;
    end
  end

  // Next digit on terminal count; the hundreds->ones step is the frame boundary.
  always_comb begin
    digit_next    = digit_reg;
    frame_edge    = 1'b0;
    scan_tc       = (prescale_reg == PRESCALE_MAX);
    prescale_next = scan_tc ? '0 : prescale_reg + 1'b1;
    if (scan_tc) begin
      case (digit_reg)
        DIG_ONES: digit_next = DIG_TENS;
        DIG_TENS: digit_next = DIG_HUNDS;
        default: begin
          digit_next = DIG_ONES;
          frame_edge = 1'b1;
        end
      endcase
    end
  end

  // Capture into the shadow slot, promote to the displayed word at the boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      active_reg  <= '0;
      err_reg     <= 1'b0;
    end else if (accept) begin
      // Only possible with pending clear, so never collides with promotion.
      shadow_reg  <= bus.bcd_in;
      pending_reg <= 1'b1;
    end else if (frame_edge && pending_reg) begin
      active_reg  <= shadow_reg;
      pending_reg <= 1'b0;
      err_reg     <= (shadow_reg[3:0] > 4'd9) | (shadow_reg[7:4] > 4'd9);
    end
  end

  // Digit select, leading-zero blanking and decode for the current index.
  always_comb begin
    nib     = 4'd0;
    blank   = 1'b0;
    an_next = 3'b000;
    case (digit_reg)
      DIG_ONES: begin
        nib     = active_reg[3:0];
        an_next = 3'b001;
      end
      DIG_TENS: begin
        nib     = active_reg[7:4];
        blank   = BLANK_LZ && (active_reg[9:8] == 2'd0) && (active_reg[7:4] == 4'd0);
        an_next = 3'b010;
      end
      DIG_HUNDS: begin
        nib     = {2'b00, active_reg[9:8]};
        blank   = BLANK_LZ && (active_reg[9:8] == 2'd0);
        an_next = 3'b100;
      end
      default: begin
        nib     = 4'd0;
        an_next = 3'b000;
      end
    endcase
    seg_next = blank ? 7'h00 : seg_decode(nib);
  end

  // Register display drive and the frame-boundary pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_reg        <= '0;
      an_reg         <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_done_reg <= frame_edge;
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;

endmodule
